// File: rtl/ldpc_parity_reader_if.sv
// ldpc_parity_reader_if
// Output stream of the LDPC parity reader toward rate matching.
// Handshake: a transfer happens on every rising clk edge where out_valid and
// out_ready are both 1; while out_valid is 1 and out_ready is 0 the producer
// holds out_block/out_index/out_last unchanged; out_valid never depends on
// out_ready.
//   out_block  parity block data (MAX_ZC bits)
//   out_valid  out_block/out_index/out_last are valid
//   out_ready  consumer accepts the current block
//   out_index  parity block index of out_block (ADDR_W bits)
//   out_last   out_block is the final block of the codeword
// master = producer (the reader), slave = consumer.
interface ldpc_parity_reader_if #(
  parameter int MAX_ZC = 384,
  parameter int ADDR_W = 9
);
  logic [MAX_ZC-1:0] out_block;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (output out_block, out_valid, out_index, out_last, input out_ready);
  modport slave  (input out_block, out_valid, out_index, out_last, output out_ready);
endinterface

// File: rtl/ldpc_parity_reader.sv
// ldpc_parity_reader
// Sweeps the LDPC encoder parity buffer once per codeword (46 blocks for BG1,
// 42 for BG2) after a rising edge of cw_vector_valid, tags each returned word
// through a RD_LATENCY-deep pipeline, and queues it in a small FIFO that feeds
// a valid/ready stream. Reads are throttled by FIFO credit only, so the FIFO
// can never overflow.
// Optional build macro: ZC_MASK_EN -- zero bits [MAX_ZC-1:zc] of every pushed
// block using the zc latched at start; when undefined parity_out passes
// through unmodified and zc is ignored.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cw_vector_valid       parity buffer complete (level, rising edge starts)
//   bg_sel, zc            base graph select / lifting size, sampled at start
//   parity_out            read data from encoder (RD_LATENCY after rd_en)
//   parity_out_address    read address (0 when no read is issued)
//   parity_out_rd_en      read strobe
//   out_if                output stream (ldpc_parity_reader_if.master)
//   busy                  reader not idle
//   cw_read_done          1-cycle pulse after the last block is accepted
//   overrun               sticky: rising edge seen while busy
//   dbg_state             FSM state (0 idle, 1 read, 2 drain)
module ldpc_parity_reader #(
  parameter int MAX_ZC            = 384,
  parameter int ADDR_W            = 9,
  parameter int BG1_PARITY_BLOCKS = 46,
  parameter int BG2_PARITY_BLOCKS = 42,
  parameter int RD_LATENCY        = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cw_vector_valid,
  input  logic                 bg_sel,
  input  logic [8:0]           zc,
  input  logic [MAX_ZC-1:0]    parity_out,
  output logic [ADDR_W-1:0]    parity_out_address,
  output logic                 parity_out_rd_en,
  ldpc_parity_reader_if.master out_if,
  output logic                 busy,
  output logic                 cw_read_done,
  output logic                 overrun,
  output logic [1:0]           dbg_state
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic              cw_q;
  logic              rise;
  logic [ADDR_W-1:0] n_total;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] addr_cnt;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [ADDR_W-1:0]     idx_pipe [RD_LATENCY];
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W:0]        used;

  logic [MAX_ZC-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] idx_mem  [FIFO_DEPTH];
  logic              last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              issue;
  logic              push;
  logic              pop;
  logic              head_last;
  logic [MAX_ZC-1:0] push_data;

  assign rise      = cw_vector_valid & ~cw_q;
  assign last_idx  = n_total - 1'b1;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Reads already issued but not yet returned occupy FIFO space too.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end
  assign used = {1'b0, count} + {1'b0, inflight};

  assign issue              = (state == ST_READ) && (used < {1'b0, DEPTH_C});
  assign parity_out_rd_en   = issue;
  assign parity_out_address = issue ? addr_cnt : '0;

  assign push      = vld_pipe[RD_LATENCY-1];
  assign pop       = out_if.out_valid && out_if.out_ready;
  assign head_last = last_mem[rd_ptr];

  // Head fields are forced to zero when empty so every output is 0 in reset.
  assign out_if.out_valid = (count != '0);
  assign out_if.out_block = out_if.out_valid ? data_mem[rd_ptr] : '0;
  assign out_if.out_index = out_if.out_valid ? idx_mem[rd_ptr]  : '0;
  assign out_if.out_last  = out_if.out_valid && head_last;

`ifdef ZC_MASK_EN
  logic [8:0]        zc_q;
  logic [MAX_ZC-1:0] zc_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          zc_q <= '0;
    else if ((state == ST_IDLE) && rise)   zc_q <= zc;
  end

  always_comb begin
    zc_mask = '0;
    for (int i = 0; i < MAX_ZC; i++) zc_mask[i] = (i < int'(zc_q));
  end
  assign push_data = parity_out & zc_mask;
`else
  logic unused_zc;
  assign unused_zc = ^zc;
  assign push_data = parity_out;
`endif

  // Control FSM, start edge detect, address counter, done/overrun flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cw_q         <= 1'b0;
      n_total      <= '0;
      addr_cnt     <= '0;
      cw_read_done <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cw_q         <= cw_vector_valid;
      cw_read_done <= 1'b0;
      if (rise && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            n_total  <= bg_sel ? ADDR_W'(BG2_PARITY_BLOCKS) : ADDR_W'(BG1_PARITY_BLOCKS);
            addr_cnt <= '0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_cnt == last_idx) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && head_last && (inflight == '0)) begin
            state        <= ST_IDLE;
            cw_read_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Return tag pipeline: stage RD_LATENCY-1 lines up with parity_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_pipe[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
      vld_pipe[0] <= issue;
      idx_pipe[0] <= addr_cnt;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      idx_mem[wr_ptr]  <= idx_pipe[RD_LATENCY-1];
      last_mem[wr_ptr] <= (idx_pipe[RD_LATENCY-1] == last_idx);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == DEPTH_C)));
endmodule

// File: tb/tb_ldpc_parity_reader.sv
module tb_ldpc_parity_reader;
  localparam int MAX_ZC     = 384;
  localparam int ADDR_W     = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int NI         = 2;   // instance g uses RD_LATENCY = g+1

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cw_vector_valid = 1'b0;
  logic        bg_sel = 1'b0;
  logic [8:0]  zc = 9'd384;
  logic        out_ready = 1'b0;
  int          ready_mode = 0;     // 0: ready=1, 1: ready=0, 2: random
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seed = 32'h0;
  logic        all_ones = 1'b0;
  int          n_cur = 0;
  int          zc_cur = 384;
  event        ev_start;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input bit ok, input string name, input logic [MAX_ZC-1:0] act,
                     input logic [MAX_ZC-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Encoder parity buffer content: a per-codeword hash of the address.
  function automatic logic [MAX_ZC-1:0] mem_word(input int unsigned a);
    logic [MAX_ZC-1:0] w;
    if (all_ones) return '1;
    for (int k = 0; k < MAX_ZC / 32; k++)
      w[k*32 +: 32] = ((a + 1) * 32'h9E37_79B9) ^ seed ^ (32'(k) * 32'h0100_0193);
    return w;
  endfunction

  function automatic logic [MAX_ZC-1:0] expect_block(input int a);
    logic [MAX_ZC-1:0] w;
    w = mem_word(a);
`ifdef ZC_MASK_EN
    for (int i = 0; i < MAX_ZC; i++) if (i >= zc_cur) w[i] = 1'b0;
`endif
    return w;
  endfunction

  // ---------------- DUT instances + per-instance scoreboard ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    ldpc_parity_reader_if #(.MAX_ZC(MAX_ZC), .ADDR_W(ADDR_W)) ifc ();
    logic [MAX_ZC-1:0] parity_out;
    logic [MAX_ZC-1:0] rd_pipe [LAT];
    logic [ADDR_W-1:0] addr;
    logic              rd_en, busy, done, ovr;
    logic [1:0]        state_dbg;

    assign ifc.out_ready = out_ready;

    ldpc_parity_reader #(
      .MAX_ZC(MAX_ZC), .ADDR_W(ADDR_W), .BG1_PARITY_BLOCKS(46), .BG2_PARITY_BLOCKS(42),
      .RD_LATENCY(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
      .clk(clk), .reset_n(reset_n), .cw_vector_valid(cw_vector_valid), .bg_sel(bg_sel),
      .zc(zc), .parity_out(parity_out), .parity_out_address(addr), .parity_out_rd_en(rd_en),
      .out_if(ifc), .busy(busy), .cw_read_done(done), .overrun(ovr), .dbg_state(state_dbg)
    );

    // Encoder read port: synchronous memory with LAT cycles of latency.
    always @(posedge clk) begin
      if (rd_en) rd_pipe[0] <= mem_word(int'(addr));
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign parity_out = rd_pipe[LAT-1];

    logic [ADDR_W:0]   exp_q[$];       // {last, index}
    logic [ADDR_W:0]   e;
    int                issued = 0, accepted = 0, rd_gap = 0, done_cnt = 0, c = 0;
    logic              held_v = 1'b0, held_last = 1'b0, last_acc_prev = 1'b0;
    logic [MAX_ZC-1:0] held_blk = '0;
    logic [ADDR_W-1:0] held_idx = '0, last_idx_seen = '0;

    always @(ev_start) begin
      exp_q.delete();
      for (int i = 0; i < n_cur; i++) exp_q.push_back({(i == n_cur - 1), ADDR_W'(i)});
      issued = 0; accepted = 0; rd_gap = 0; done_cnt = 0;
      c = 0;
      do begin @(negedge clk); c++; end while (!ifc.out_valid && c < 20);
      chk(c == LAT + 3, $sformatf("first_valid_lat_l%0d", LAT), c, LAT + 3);
    end

    always @(negedge clk) begin
      if (!reset_n) begin
        exp_q.delete();
        issued = 0; accepted = 0;
        held_v = 1'b0; last_acc_prev = 1'b0;
      end else begin
        if (rd_en) begin
          chk(addr == ADDR_W'(issued), $sformatf("rd_addr_l%0d", LAT), addr, issued);
          chk(issued < n_cur, $sformatf("rd_range_l%0d", LAT), issued, n_cur);
          issued++;
        end else if (issued > 0 && issued < n_cur) rd_gap++;
        chk(issued - accepted <= FIFO_DEPTH, $sformatf("credit_l%0d", LAT),
            issued - accepted, FIFO_DEPTH);
        if (held_v)
          chk(ifc.out_valid && ifc.out_block == held_blk && ifc.out_index == held_idx &&
              ifc.out_last == held_last, $sformatf("hold_l%0d", LAT),
              {ifc.out_valid, ifc.out_last, ifc.out_index}, {1'b1, held_last, held_idx});
        chk(done == last_acc_prev, $sformatf("done_pulse_l%0d", LAT), done, last_acc_prev);
        if (done) done_cnt++;
        last_acc_prev = 1'b0;
        if (ifc.out_valid && out_ready) begin
          chk(exp_q.size() != 0, $sformatf("unexpected_block_l%0d", LAT), ifc.out_index, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({ifc.out_last, ifc.out_index} == e, $sformatf("index_last_l%0d", LAT),
                {ifc.out_last, ifc.out_index}, e);
            chk(ifc.out_block == expect_block(int'(e[ADDR_W-1:0])),
                $sformatf("block_l%0d", LAT), ifc.out_block, expect_block(int'(e[ADDR_W-1:0])));
            last_acc_prev = e[ADDR_W];
          end
          if (ifc.out_last) last_idx_seen = ifc.out_index;
          accepted++;
        end
        held_v    = ifc.out_valid && !out_ready;
        held_blk  = ifc.out_block;
        held_idx  = ifc.out_index;
        held_last = ifc.out_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cw(input logic bg, input int z);
    @(posedge clk); #1;
    cw_vector_valid = 1'b0;
    @(posedge clk); #1;
    bg_sel = bg; zc = 9'(z); zc_cur = z; seed = $urandom;
    n_cur = bg ? 42 : 46;
    cw_vector_valid = 1'b1;
    -> ev_start;
    @(negedge clk);
    chk(g_inst[0].busy == 1'b0, "busy_before_edge", g_inst[0].busy, 0);
    @(negedge clk);
    chk(g_inst[0].busy == 1'b1 && g_inst[1].busy == 1'b1, "busy_rise",
        {g_inst[1].busy, g_inst[0].busy}, 2'b11);
  endtask

  task automatic wait_accepted(input int n);
    int cyc = 0;
    while (g_inst[0].accepted < n && cyc < 1000) begin @(negedge clk); cyc++; end
    chk(cyc < 1000, "accept_timeout", cyc, 1000);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!(g_inst[0].done_cnt > 0 && g_inst[1].done_cnt > 0) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk(cyc < 2000, {tag, "_done_timeout"}, cyc, 2000);
    repeat (3) @(negedge clk);
    chk(g_inst[0].exp_q.size() == 0 && g_inst[1].exp_q.size() == 0, {tag, "_drained"},
        g_inst[0].exp_q.size() + g_inst[1].exp_q.size(), 0);
    chk(g_inst[0].issued == n_cur && g_inst[1].issued == n_cur, {tag, "_read_count"},
        {g_inst[1].issued[15:0], g_inst[0].issued[15:0]}, {n_cur[15:0], n_cur[15:0]});
    chk(g_inst[0].done_cnt == 1 && g_inst[1].done_cnt == 1, {tag, "_done_once"},
        {g_inst[1].done_cnt[7:0], g_inst[0].done_cnt[7:0]}, 16'h0101);
  endtask

  task automatic chk_zero(input string tag, input logic [MAX_ZC-1:0] blk, input logic [31:0] ctl);
    chk(blk == '0, {tag, "_block"}, blk, 0);
    chk(ctl == '0, {tag, "_ctl"}, ctl, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_zero({tag, "_l1"}, g_inst[0].ifc.out_block,
             {8'h0, g_inst[0].addr, g_inst[0].ifc.out_index, g_inst[0].rd_en,
              g_inst[0].ifc.out_valid, g_inst[0].ifc.out_last, g_inst[0].busy,
              g_inst[0].done, g_inst[0].ovr});
    chk_zero({tag, "_l2"}, g_inst[1].ifc.out_block,
             {8'h0, g_inst[1].addr, g_inst[1].ifc.out_index, g_inst[1].rd_en,
              g_inst[1].ifc.out_valid, g_inst[1].ifc.out_last, g_inst[1].busy,
              g_inst[1].done, g_inst[1].ovr});
  endtask

  // ---------------- main sequence ----------------
  logic [MAX_ZC-1:0] lit;
  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // BG1, full lifting size, consumer always ready
    ready_mode = 0;
    start_cw(1'b0, 384);
    wait_done("bg1");
    chk(g_inst[0].rd_gap == 0 && g_inst[1].rd_gap == 0, "bg1_back_to_back",
        {g_inst[1].rd_gap[15:0], g_inst[0].rd_gap[15:0]}, 0);
    chk(g_inst[0].last_idx_seen == 9'd45 && g_inst[1].last_idx_seen == 9'd45, "bg1_last_idx",
        {g_inst[1].last_idx_seen, g_inst[0].last_idx_seen}, {9'd45, 9'd45});

    // BG2, random lifting size and random consumer
    ready_mode = 2;
    start_cw(1'b1, int'($urandom_range(1, 384)));
    wait_done("bg2");
    chk(g_inst[0].last_idx_seen == 9'd41 && g_inst[1].last_idx_seen == 9'd41, "bg2_last_idx",
        {g_inst[1].last_idx_seen, g_inst[0].last_idx_seen}, {9'd41, 9'd41});

    // Backpressure: consumer stalled for 20 cycles after start
    ready_mode = 1;
    start_cw(1'b0, 384);
    repeat (18) @(negedge clk);
    chk(g_inst[0].issued == FIFO_DEPTH && g_inst[1].issued == FIFO_DEPTH, "stall_reads",
        {g_inst[1].issued[15:0], g_inst[0].issued[15:0]}, {16'(FIFO_DEPTH), 16'(FIFO_DEPTH)});
    ready_mode = 2;
    wait_done("stall");

    // Re-trigger while busy, level held after done, then a fresh edge
    ready_mode = 0;
    start_cw(1'b0, 384);
    wait_accepted(10);
    @(posedge clk); #1 cw_vector_valid = 1'b0;
    @(posedge clk); #1 cw_vector_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk(g_inst[0].ovr == 1'b1 && g_inst[1].ovr == 1'b1, "overrun_set",
        {g_inst[1].ovr, g_inst[0].ovr}, 2'b11);
    wait_done("retrig");
    repeat (10) @(negedge clk);
    chk(g_inst[0].busy == 1'b0 && g_inst[1].busy == 1'b0, "level_no_restart",
        {g_inst[1].busy, g_inst[0].busy}, 0);
    chk(g_inst[0].ovr == 1'b1 && g_inst[1].ovr == 1'b1, "overrun_sticky",
        {g_inst[1].ovr, g_inst[0].ovr}, 2'b11);
    start_cw(1'b0, 384);
    wait_done("fresh");
    chk(g_inst[0].last_idx_seen == 9'd45, "fresh_last_idx", g_inst[0].last_idx_seen, 45);

    // Reset in the middle of a codeword, then restart from address 0
    ready_mode = 2;
    start_cw(1'b0, 384);
    wait_accepted(20);
    @(posedge clk); #1;
    reset_n = 1'b0;
    cw_vector_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    start_cw(1'b1, 384);
    wait_done("after_reset");

    // All-ones parity buffer with zc = 208
    all_ones = 1'b1;
    ready_mode = 0;
    start_cw(1'b0, 208);
`ifdef ZC_MASK_EN
    lit = {{176{1'b0}}, {208{1'b1}}};
`else
    lit = {384{1'b1}};
`endif
    begin
      int cyc = 0;
      while (!g_inst[0].ifc.out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      chk(g_inst[0].ifc.out_block == lit, "zc208_block", g_inst[0].ifc.out_block, lit);
    end
    wait_done("zc208");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ldpc_parity_reader.md
Name: ldpc_parity_reader

Overview:
Read-side companion of LDPC_encoder. It sweeps the encoder's parity buffer through parity_out_address/parity_out_rd_en once cw_vector_valid rises, and captures each returned parity_out block. Blocks go into a small skid FIFO and leave on a valid/ready stream toward rate matching. BG1 codewords read 46 parity blocks (4 gap + 42 non-gap); BG2 codewords read 42 (4 gap + 38 non-gap).

Parameters:
MAX_ZC, 384, width of one parity block
ADDR_W, 9, width of parity_out_address
BG1_PARITY_BLOCKS, 46, blocks read per BG1 codeword
BG2_PARITY_BLOCKS, 42, blocks read per BG2 codeword
RD_LATENCY, 1, cycles from rd_en to parity_out valid (1 or 2)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= RD_LATENCY+1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cw_vector_valid  in  1  encoder parity buffer complete (level)
bg_sel  in  1  0=BG1, 1=BG2; sampled at start
zc  in  9  lifting size; sampled at start
parity_out  in  MAX_ZC  read data from encoder
parity_out_address  out  ADDR_W  read address
parity_out_rd_en  out  1  read strobe
out_block  out  MAX_ZC  FIFO head data
out_valid  out  1  out_block valid
out_ready  in  1  downstream accept
out_index  out  ADDR_W  parity block index of out_block
out_last  out  1  out_block is final block of codeword
busy  out  1  reader active (not IDLE)
cw_read_done  out  1  one-cycle pulse when last block accepted
overrun  out  1  sticky: cw_vector_valid rise while busy

Behaviour:
- Reset: all outputs 0; FSM=IDLE; FIFO empty; address counter 0; overrun cleared. Assertion mid-operation aborts immediately. Block reads and FIFO contents are discarded.
- Start: rising edge of cw_vector_valid (registered edge detect) in IDLE. Latch bg_sel and zc, set total N=46/42, go to READ. busy rises on the following cycle.
- READ: assert rd_en with address A (starting at 0) when credit > 0. Credit = FIFO_DEPTH - fifo_count - inflight. A increments per issued read; after issuing A=N-1, go to DRAIN. Never stall rd_en for other reasons.
- Read data: a RD_LATENCY-deep valid/index shift pipeline tags parity_out. Each returned word pushes {data, index, last=(index==N-1)} into the FIFO. Credit accounting guarantees a push never meets a full FIFO. Overflow is an assertion-level error.
- Output: out_valid = FIFO not empty. Pop on out_valid && out_ready. out_block/out_index/out_last stay stable while out_valid && !out_ready.
- DRAIN: wait until inflight=0 and the entry with out_last is popped. Then pulse cw_read_done for 1 cycle and return to IDLE.
- Throughput: with out_ready held 1, one block per cycle. First out_valid appears RD_LATENCY+1 cycles after the start edge is registered.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged. Push into empty: out_valid rises next cycle (no fall-through).
- cw_vector_valid rise while busy: ignored, overrun set (sticky until reset). A level held high after DONE does not restart; a new rising edge is required.
- Address counter is ADDR_W bits and never wraps within a codeword (N<2^ADDR_W).

Optional Feature:
ZC_MASK_EN: when defined, bits [MAX_ZC-1:zc] of every pushed block are forced to 0. Only the lower zc bits are meaningful; upper bits are zero. Mask is computed from the latched zc. When undefined, parity_out is passed through unmodified and zc is unused.

Test Plan:
- BG1, zc=384, out_ready=1: cw_vector_valid rises -> addresses 0..45 issued on consecutive cycles; 46 blocks out in order; out_last on index 45; cw_read_done one pulse after it.
- BG2, zc=384: -> exactly 42 reads; out_last at index 41; no address 42 ever driven.
- Backpressure: out_ready=0 for 20 cycles after start -> at most FIFO_DEPTH reads issued, out_block held stable. After release, the remaining blocks follow with no loss or duplication (check data = address-pattern memory model), for RD_LATENCY=1 and 2.
- Re-trigger: second cw_vector_valid edge at block 10 -> overrun=1, sequence continues unaffected; fresh edge after done -> new 46-block pass.
- Reset at block 20 -> all outputs 0 within the reset, FIFO empty. Next start begins at address 0.
- ZC_MASK_EN defined, zc=208, parity_out all ones -> out_block[383:208]=0, [207:0]=1. Undefined -> all ones.
